// File: rtl/inst_rom_pkg.sv
// Shared constants, state encoding and address helpers for the instruction ROM.
// No logic of its own; imported by inst_rom and inst_rom_array.
// Holds XLEN, the NOP encoding returned on faults and the wait-counter width.
package inst_rom_pkg;

    // Machine word width and its bit-width companion
    localparam int XLEN           = 32;
    localparam int XLEN_WIDTH     = 5;

    // Wait-state counter width; WAIT_CYCLES must fit in it (0..15)
    localparam int ROM_WAIT_WIDTH = 4;

    // addi x0, x0, 0 -- returned in place of data on any faulting fetch
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } rom_state_t;

    // Word offset of a byte address relative to the ROM base.
    // The caller range-checks the full result before truncating it to an index,
    // so an address beyond the array can never alias onto a low word.
    function automatic logic [XLEN-1:0] rom_word_of(input logic [XLEN-1:0] addr,
                                                    input logic [XLEN-1:0] base);
        return (addr - base) >> 2;
    endfunction

    // True when the byte address does not point at the first byte of a word
    function automatic logic rom_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/inst_rom_array.sv
// DEPTH x WIDTH word storage: synchronous write port, combinational read port.
// Latency: write lands on the clock edge, read data follows raddr in the same cycle.
// Backpressure: none; the write port is always accepted, contents are never reset.
module inst_rom_array
    import inst_rom_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int WIDTH = XLEN,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Word write from the load port; storage deliberately has no reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom.sv
// Instruction ROM responder: fetch request in, one registered word/error pulse out.
// Latency: rom_valid exactly WAIT_CYCLES+1 cycles after the accept edge; 1 word/cycle when WAIT_CYCLES=0.
// Backpressure: rom_ready low while busy or while load_we is high. Optional ROM_MISALIGN_CHECK_EN faults misaligned fetches.
module inst_rom
    import inst_rom_pkg::*;
#(
    parameter int              DEPTH       = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int              WAIT_CYCLES = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rom_req,
    input  logic [XLEN-1:0] rom_addr,
    output logic            rom_ready,
    output logic            rom_valid,
    output logic [XLEN-1:0] rom_data,
    output logic            rom_err,
    input  logic            load_we,
    input  logic [XLEN-1:0] load_addr,
    input  logic [XLEN-1:0] load_data
);

    // DEPTH is a power of two and at least 2, so AW is a clean index width
    localparam int   AW        = $clog2(DEPTH);
    localparam logic ZERO_WAIT = (WAIT_CYCLES == 0);

    rom_state_t              state;
    logic [ROM_WAIT_WIDTH-1:0] cnt;
    logic [AW-1:0]           cap_idx;
    logic                    cap_err;

    logic [XLEN-1:0]         req_word;
    logic                    req_in_range;
    logic                    req_err;
    logic [AW-1:0]           req_idx;
    logic                    accept;

    logic [XLEN-1:0]         load_word;
    logic                    load_in_range;
    logic                    mem_we;
    logic [AW-1:0]           load_idx;

    logic [AW-1:0]           rd_idx;
    logic [XLEN-1:0]         rd_data;

    // Fetch address decode: range check on the full offset, then truncate
    assign req_word     = rom_word_of(rom_addr, BASE_ADDR);
    assign req_in_range = (rom_addr >= BASE_ADDR) && (req_word < XLEN'(DEPTH));
    assign req_idx      = req_word[AW-1:0];

`ifdef ROM_MISALIGN_CHECK_EN
    assign req_err = !req_in_range || rom_misaligned(rom_addr);
`else
    assign req_err = !req_in_range;
`endif

    // Load port decode; low two address bits drop out in the word shift
    assign load_word     = rom_word_of(load_addr, BASE_ADDR);
    assign load_in_range = (load_addr >= BASE_ADDR) && (load_word < XLEN'(DEPTH));
    assign load_idx      = load_word[AW-1:0];
    assign mem_we        = load_we && load_in_range;

    // Loads win over fetches; back-to-back accepts only exist without wait states
    assign rom_ready = !load_we && ((state == ST_IDLE) || ((state == ST_RESP) && ZERO_WAIT));
    assign accept    = rom_req && rom_ready;

    // While waiting, the array is read at the captured index so the response
    // reflects any load that landed during the wait; otherwise read the live request
    assign rd_idx = (state == ST_WAIT) ? cap_idx : req_idx;

    inst_rom_array #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (load_idx),
        .wdata (load_data),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

    // Request FSM with registered response outputs; rom_valid mirrors the RESP state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cap_idx   <= '0;
            cap_err   <= 1'b0;
            rom_valid <= 1'b0;
            rom_err   <= 1'b0;
            rom_data  <= '0;
        end else begin
            rom_valid <= 1'b0;
            rom_err   <= 1'b0;
            case (state)
                ST_IDLE, ST_RESP: begin
                    if (accept) begin
                        cap_idx <= req_idx;
                        cap_err <= req_err;
                        if (ZERO_WAIT) begin
                            state     <= ST_RESP;
                            rom_valid <= 1'b1;
                            rom_err   <= req_err;
                            rom_data  <= req_err ? INST_NOP : rd_data;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= ROM_WAIT_WIDTH'(WAIT_CYCLES - 1);
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state     <= ST_RESP;
                        rom_valid <= 1'b1;
                        rom_err   <= cap_err;
                        rom_data  <= cap_err ? INST_NOP : rd_data;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_rom.sv
// Bench for inst_rom: two instances (no wait states, three wait states) share one stimulus stream.
// Expected outputs come from a response-schedule model: each accepted fetch is due at a known edge.
// Directed cases first, then randomized fetch/load/reset traffic.
module tb_inst_rom;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rom_req = 1'b0;
    logic [31:0] rom_addr = '0;
    logic        load_we = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;

    logic        rdy0, vld0, err0;
    logic [31:0] dat0;
    logic        rdy3, vld3, err3;
    logic [31:0] dat3;

    inst_rom #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .rom_req(rom_req), .rom_addr(rom_addr),
        .rom_ready(rdy0), .rom_valid(vld0), .rom_data(dat0), .rom_err(err0),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
    );

    inst_rom #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst), .rom_req(rom_req), .rom_addr(rom_addr),
        .rom_ready(rdy3), .rom_valid(vld3), .rom_data(dat3), .rom_err(err3),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: memory image, edge count and per-instance schedule
    logic [31:0] mem [DEPTH];
    int          edge_no = 0;
    int          wc [2] = '{0, 3};
    int          resp_edge [2];
    int          pend_idx [2];
    bit          pend_err [2];
    bit          acc [2];
    bit          exp_vld [2];
    bit          exp_err [2];
    logic [31:0] exp_dat [2];

    function automatic bit in_rng(input logic [31:0] a);
        longint la = longint'(a);
        return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * DEPTH);
    endfunction

    function automatic int word_idx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic bit bad_fetch(input logic [31:0] a);
`ifdef ROM_MISALIGN_CHECK_EN
        return !in_rng(a) || (a % 4 != 0);
`else
        return !in_rng(a);
`endif
    endfunction

    // A fetch is accepted unless a load is present or the previous one is still pending
    function automatic bit model_ready(input int d);
        if (load_we) return 1'b0;
        if (wc[d] == 0) return 1'b1;
        return edge_no > resp_edge[d];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", nm, act, exp, edge_no);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            resp_edge[d] = -1;
            acc[d]       = 1'b0;
            exp_vld[d]   = 1'b0;
            exp_err[d]   = 1'b0;
            exp_dat[d]   = '0;
        end
    endtask

    // Advance the model by one clock edge using the inputs held across it
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            exp_vld[d] = 1'b0;
            exp_err[d] = 1'b0;
            if (acc[d]) begin
                resp_edge[d] = edge_no + wc[d];
                pend_idx[d]  = word_idx(rom_addr);
                pend_err[d]  = bad_fetch(rom_addr);
            end
            if (resp_edge[d] == edge_no) begin
                exp_vld[d] = 1'b1;
                exp_err[d] = pend_err[d];
                exp_dat[d] = pend_err[d] ? NOP : mem[pend_idx[d]];
            end
        end
        if (load_we && in_rng(load_addr)) mem[word_idx(load_addr)] = load_data;
    endtask

    task automatic compare_outputs();
        check("valid_w0", {31'b0, vld0}, {31'b0, exp_vld[0]});
        check("err_w0",   {31'b0, err0}, {31'b0, exp_err[0]});
        check("data_w0",  dat0, exp_dat[0]);
        check("valid_w3", {31'b0, vld3}, {31'b0, exp_vld[1]});
        check("err_w3",   {31'b0, err3}, {31'b0, exp_err[1]});
        check("data_w3",  dat3, exp_dat[1]);
    endtask

    // One clock: check ready before the edge, outputs at the following negedge
    task automatic step();
        bit mr0, mr3;
        #1;
        mr0 = model_ready(0);
        mr3 = model_ready(1);
        acc[0] = rom_req && mr0;
        acc[1] = rom_req && mr3;
        check("ready_w0", {31'b0, rdy0}, {31'b0, mr0});
        check("ready_w3", {31'b0, rdy3}, {31'b0, mr3});
        @(posedge clk);
        edge_no++;
        n_vec++;
        model_edge();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic idle(input int n);
        rom_req = 1'b0;
        load_we = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] v);
        rom_req   = 1'b0;
        load_we   = 1'b1;
        load_addr = a;
        load_data = v;
        step();
        load_we = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        rom_req  = 1'b1;
        rom_addr = a;
        step();
        rom_req = 1'b0;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge
    task automatic do_reset();
        rom_req = 1'b0;
        load_we = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_outputs();
        check("async_rst_vld_w3", {31'b0, vld3}, 32'd0);
        @(posedge clk);
        edge_no++;
        @(negedge clk);
        compare_outputs();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] pick_addr();
        int r = $urandom_range(0, 9);
        logic [31:0] a;
        logic [31:0] oob [5] = '{32'h0000_1000, 32'h0000_1004, 32'hFFFF_FFFC, 32'h8000_0000, 32'h0000_2000};
        if (r < 6)      a = BASE + 32'($urandom_range(0, 15)) * 4;
        else if (r < 8) a = BASE + 32'($urandom_range(1020, 1023)) * 4;
        else            a = oob[$urandom_range(0, 4)];
        if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
        return a;
    endfunction

    initial begin
        model_reset();

        // Reset state
        @(negedge clk);
        check("reset_vld_w0", {31'b0, vld0}, 32'd0);
        check("reset_err_w0", {31'b0, err0}, 32'd0);
        check("reset_dat_w0", dat0, 32'd0);
        check("reset_dat_w3", dat3, 32'd0);
        check("reset_rdy_w3", {31'b0, rdy3}, 32'd1);
        rst = 1'b0;

        // Program image: words 0..15 and the last four words of the array
        for (int i = 0; i < 16; i++) begin
            if (i == 0)      load(32'h0, 32'h0050_0093);
            else if (i == 1) load(32'h4, 32'h0010_8113);
            else             load(BASE + 32'(i) * 4, $urandom);
        end
        for (int i = 1020; i < 1024; i++) load(BASE + 32'(i) * 4, $urandom);
        load(32'h0000_0009, 32'h1234_5678);   // low bits ignored: lands in word 2
        load(32'h0000_1000, 32'hDEAD_BEEF);   // out of range: dropped

        // Back-to-back fetches with no wait states
        rom_req = 1'b1; rom_addr = 32'h0; step();
        check("b2b_first_vld", {31'b0, vld0}, 32'd1);
        check("b2b_first_dat", dat0, 32'h0050_0093);
        rom_addr = 32'h4; step();
        check("b2b_second_vld", {31'b0, vld0}, 32'd1);
        check("b2b_second_dat", dat0, 32'h0010_8113);
        check("b2b_second_err", {31'b0, err0}, 32'd0);
        rom_req = 1'b0; step();
        check("b2b_done_vld", {31'b0, vld0}, 32'd0);
        check("b2b_hold_dat", dat0, 32'h0010_8113);
        idle(4);
        fetch(32'h8);
        check("load_lowbits_dat", dat0, 32'h1234_5678);
        idle(4);

        // Three wait states: busy for three cycles, response on the fourth
        fetch(32'h4);
        for (int k = 0; k < 3; k++) begin
            check("wait_rdy_w3", {31'b0, rdy3}, 32'd0);
            check("wait_vld_w3", {31'b0, vld3}, 32'd0);
            step();
        end
        check("wait_resp_vld_w3", {31'b0, vld3}, 32'd1);
        check("wait_resp_dat_w3", dat3, 32'h0010_8113);
        idle(2);

        // Out of range and last in-range word
        fetch(32'h0000_1000);
        check("oob_vld", {31'b0, vld0}, 32'd1);
        check("oob_err", {31'b0, err0}, 32'd1);
        check("oob_dat", dat0, NOP);
        idle(4);
        fetch(32'h0000_0FFC);
        check("last_word_err", {31'b0, err0}, 32'd0);
        idle(4);

        // Load/fetch collision: load wins, fetch accepted after it sees the new word
        rom_req = 1'b1; rom_addr = 32'h8;
        load_we = 1'b1; load_addr = 32'h8; load_data = 32'hCAFE_0001;
        #1;
        check("collide_rdy_w0", {31'b0, rdy0}, 32'd0);
        step();
        load_we = 1'b0; step();
        check("collide_dat_w0", dat0, 32'hCAFE_0001);
        rom_req = 1'b0;
        step(); step(); step();
        check("collide_vld_w3", {31'b0, vld3}, 32'd1);
        check("collide_dat_w3", dat3, 32'hCAFE_0001);
        idle(2);

        // Reset one cycle into the wait: the pending response is discarded
        fetch(32'h4);
        step();
        do_reset();
        idle(6);
        fetch(32'h0);
        step(); step(); step();
        check("post_rst_vld_w3", {31'b0, vld3}, 32'd1);
        check("post_rst_dat_w3", dat3, 32'h0050_0093);
        idle(2);

        // Misaligned fetch
        fetch(32'h6);
`ifdef ROM_MISALIGN_CHECK_EN
        check("misalign_err", {31'b0, err0}, 32'd1);
        check("misalign_dat", dat0, NOP);
`else
        check("misalign_err", {31'b0, err0}, 32'd0);
        check("misalign_dat", dat0, 32'h0010_8113);
`endif
        idle(4);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                rom_req   = ($urandom_range(0, 9) < 7);
                rom_addr  = pick_addr();
                load_we   = ($urandom_range(0, 9) < 2);
                load_addr = pick_addr();
                load_data = $urandom;
                step();
            end
        end
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_rom.md
Name: inst_rom

Overview:
- Instruction memory responder that sits on the far side of the fetch unit's ROM interface.
- Accepts a fetch request on rom_addr and returns the word on rom_data after a fixed, parameterised latency.
- Word-wide load port lets the testbench or boot loader write the program image.
- Request/valid handshake, wait-state counter and range/alignment error reporting, so the fetch side can be exercised against slow or faulting memory.

Parameters:
- DEPTH, 1024: number of XLEN-bit words stored; power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- WAIT_CYCLES, 0: extra cycles between request acceptance and response; range 0..15.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- rom_req  input  1  fetch request
- rom_addr  input  XLEN  byte address of the fetch
- rom_ready  output  1  request can be accepted this cycle
- rom_valid  output  1  rom_data/rom_err valid this cycle (one-cycle pulse per request)
- rom_data  output  XLEN  fetched instruction word
- rom_err  output  1  request was out of range (or misaligned, see optional feature)
- load_we  input  1  load-port word write enable
- load_addr  input  XLEN  load-port byte address; bits [1:0] ignored
- load_data  input  XLEN  load-port write data

Behaviour:
- Reset (asynchronous, active-high, clock clk):
  - rom_valid=0, rom_err=0, rom_data=0.
  - FSM in IDLE, wait counter=0, captured address=0.
  - Memory contents are not reset.
- Word index = (rom_addr - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits after the range check.
- In range iff BASE_ADDR <= rom_addr < BASE_ADDR + 4*DEPTH.
- Acceptance: a request is accepted on a rising edge with rom_req && rom_ready. The index and range flag are captured at acceptance; later rom_addr changes have no effect.
- rom_ready = !load_we && (state==IDLE || (state==RESP && WAIT_CYCLES==0)).
- FSM states:
  - IDLE: on accept, go to WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1), else RESP.
  - WAIT: counter decrements each cycle; at 0, go to RESP.
  - RESP: rom_valid=1 this cycle. On a same-cycle accept (only possible when WAIT_CYCLES==0), stay in RESP. Otherwise go to IDLE.
- Latency:
  - rom_valid is asserted exactly WAIT_CYCLES+1 cycles after the accept edge.
  - With WAIT_CYCLES=0, back-to-back requests give one word per cycle.
- Response data:
  - In range: rom_data = the memory word at the captured index, read in the cycle the response is registered.
  - Out of range: rom_data=`INST_NOP (32'h0000_0013) and rom_err=1.
  - rom_data holds its last value while rom_valid=0; rom_err is cleared when rom_valid=0.
- Load port:
  - Synchronous word write on load_we when load_addr is in range; out-of-range loads are silently dropped.
  - load_we forces rom_ready=0, so loads have priority over new fetches.
  - A fetch already in WAIT completes normally. If it targets the same word, it returns the value present in the cycle its response is registered (new data if the load happened earlier).
- Reset mid-operation: any pending WAIT/RESP is discarded; no rom_valid is produced for it.
- Index wrap-around is impossible, because out-of-range addresses are trapped before truncation.

Optional Feature:
- Macro: ROM_MISALIGN_CHECK_EN.
- Defined: a fetch with rom_addr[1:0]!=0 is accepted normally but responds with rom_err=1 and rom_data=`INST_NOP, at the same latency as any other request.
- Undefined: rom_addr[1:0] are ignored; a misaligned fetch returns the containing word with rom_err=0.

Decomposition:
- Shared defines:
  - XLEN/`XLEN_WIDTH stay in define/const.v.
  - Add `INST_NOP to define/inst.v.
  - Add `ROM_WAIT_WIDTH (4) to define/const.v.
- One natural sub-module: inst_rom_array, a DEPTH x XLEN storage array with synchronous write and combinational read. inst_rom keeps the FSM, counter, range check and output registers.

Test Plan:
- WAIT_CYCLES=0: load 0x00500093 at 0x0 and 0x00108113 at 0x4, then req 0x0 and 0x4 on consecutive cycles -> rom_valid on the next two cycles with those words in order, rom_err=0.
- WAIT_CYCLES=3: req 0x4 accepted at cycle N -> rom_ready=0 for cycles N+1..N+3, rom_valid and data 0x00108113 only at N+4.
- Out of range (DEPTH=1024): req 0x1000 -> rom_valid with rom_err=1 and rom_data=0x00000013.
- Load/fetch collision: load_we high with rom_req high -> rom_ready=0 and no accept; request accepted the cycle after load_we drops, returning the newly loaded word.
- Async reset asserted during WAIT (WAIT_CYCLES=3, one cycle after accept) -> outputs 0 immediately; no rom_valid after reset release; the next request is served normally.
- ROM_MISALIGN_CHECK_EN defined: req 0x6 -> rom_err=1, rom_data=0x00000013. Undefined: req 0x6 -> word at 0x4, rom_err=0.
